// File: rtl/mem_stage_hs.sv
// MEM stage: DM/bridge load select, req/ack bridge handshake with stall and timeout,
// load extension, MEM bypass and MEM/WB register. Optional macro: MEM_MISALIGN_CHK_EN.
module mem_stage_hs #(
  parameter int unsigned RW_W       = 5,
  parameter int unsigned ADDR_CMP_W = 16,
  parameter int unsigned DM_LIMIT   = 'h3000,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [31:0]     in_ex_out,
  input  logic [RW_W-1:0] in_rw,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic            in_is_byte,
  input  logic            in_is_half,
  input  logic            in_is_loads,
  input  logic            in_is_store,
  input  logic [31:0]     in_store_data,
  input  logic [31:0]     in_dm_out,
  output logic            br_req,
  output logic            br_we,
  output logic [31:0]     br_addr,
  output logic [31:0]     br_wdata,
  input  logic [31:0]     br_rdata,
  input  logic            br_ack,
  output logic            stall_req,
  output logic            bus_err,
  output logic            byp_reg_write,
  output logic [31:0]     byp_wd,
  output logic [RW_W-1:0] byp_rw,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [31:0]     wb_wd,
  output logic [RW_W-1:0] wb_rw
`ifdef MEM_MISALIGN_CHK_EN
  ,
  output logic            misalign
`endif
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [ADDR_CMP_W-1:0] DM_LIM = ADDR_CMP_W'(DM_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_br_req;
  logic            r_br_we;
  logic [31:0]     r_br_addr;
  logic [31:0]     r_br_wdata;
  logic [31:0]     r_rdata_q;
  logic            r_bus_err;
  logic            r_wb_valid;
  logic            r_wb_reg_write;
  logic [31:0]     r_wb_wd;
  logic [RW_W-1:0] r_wb_rw;

  logic            w_misalign;
  logic            w_periph;
  logic            w_stall;
  logic [31:0]     w_raw;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ext;
  logic [31:0]     w_wd;

`ifdef MEM_MISALIGN_CHK_EN
  logic r_misalign;

  assign w_misalign = in_valid & (in_mem_to_reg | in_is_store) &
                      ((in_is_half & in_ex_out[0]) |
                       (~in_is_byte & ~in_is_half & (in_ex_out[1:0] != 2'b00)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_misalign <= 1'b0;
    else      r_misalign <= w_misalign;
  end

  assign misalign = r_misalign;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_periph = in_valid & (in_mem_to_reg | in_is_store) &
                    (in_ex_out[ADDR_CMP_W-1:0] >= DM_LIM) & ~w_misalign;

  // IDLE raises the stall combinationally so the access never slips past MEM;
  // gated by rst so every output is quiet while reset is held.
  assign w_stall = rst & (((r_state == S_IDLE) & w_periph) | (r_state == S_WAIT));

  always_comb begin
    w_raw = (r_state == S_DONE) ? r_rdata_q : in_dm_out;
    case (in_ex_out[1:0])
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
    w_half = in_ex_out[1] ? w_raw[31:16] : w_raw[15:0];
    if (in_is_byte)      w_ext = {{24{in_is_loads & w_byte[7]}}, w_byte};
    else if (in_is_half) w_ext = {{16{in_is_loads & w_half[15]}}, w_half};
    else                 w_ext = w_raw;
    w_wd = in_mem_to_reg ? w_ext : in_ex_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_br_req   <= 1'b0;
      r_br_we    <= 1'b0;
      r_br_addr  <= '0;
      r_br_wdata <= '0;
      r_rdata_q  <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_periph && !flush) begin
            r_state    <= S_WAIT;
            r_br_req   <= 1'b1;
            r_br_addr  <= in_ex_out;
            r_br_we    <= in_is_store;
            r_br_wdata <= in_store_data;
            r_cnt      <= '0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (flush) begin
            r_state  <= S_IDLE;
            r_br_req <= 1'b0;
          end else if (br_ack) begin
            r_state   <= S_DONE;
            r_br_req  <= 1'b0;
            r_rdata_q <= br_rdata;
          end else if (r_cnt == TO_LAST) begin
            r_state   <= S_DONE;
            r_br_req  <= 1'b0;
            r_rdata_q <= '0;
            r_bus_err <= 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_wd        <= '0;
      r_wb_rw        <= '0;
    end else if (flush || w_stall) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
    end else begin
      r_wb_valid     <= in_valid;
      r_wb_reg_write <= in_valid & in_reg_write & ~w_misalign;
      r_wb_wd        <= w_wd;
      r_wb_rw        <= in_rw;
    end
  end

  assign br_req        = r_br_req;
  assign br_we         = r_br_we;
  assign br_addr       = r_br_addr;
  assign br_wdata      = r_br_wdata;
  assign bus_err       = r_bus_err;
  assign stall_req     = w_stall;
  assign byp_reg_write = in_valid & in_reg_write;
  assign byp_wd        = in_ex_out;
  assign byp_rw        = in_rw;
  assign wb_valid      = r_wb_valid;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_wd         = r_wb_wd;
  assign wb_rw         = r_wb_rw;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: vector table, random transactions against a rule-level model,
// and hand sequences for flush, reset and (with MEM_MISALIGN_CHK_EN) misalignment.
module tb_mem_stage_hs;

  localparam int TIMEOUT = 15;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] wdata;
    bit          st, m2r, regw, bt, hf, sg;
    logic [4:0]  rw;
    int          ack_at;
    logic [31:0] exp_wd;
    bit          exp_wrw;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ex_out = '0;
  logic [4:0]  in_rw = '0;
  logic        in_reg_write = 1'b0, in_mem_to_reg = 1'b0, in_is_byte = 1'b0;
  logic        in_is_half = 1'b0, in_is_loads = 1'b0, in_is_store = 1'b0;
  logic [31:0] in_store_data = '0, in_dm_out = '0, br_rdata = '0;
  logic        br_ack = 1'b0;
  logic        br_req, br_we, stall_req, bus_err, byp_reg_write;
  logic        wb_valid, wb_reg_write;
  logic [31:0] br_addr, br_wdata, byp_wd, wb_wd;
  logic [4:0]  byp_rw, wb_rw;
`ifdef MEM_MISALIGN_CHK_EN
  logic        misalign;
`endif

  int checks = 0;
  int failures = 0;

  mem_stage_hs #(.RW_W(5), .ADDR_CMP_W(16), .DM_LIMIT('h3000), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ex_out(in_ex_out),
    .in_rw(in_rw), .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_is_byte(in_is_byte), .in_is_half(in_is_half), .in_is_loads(in_is_loads),
    .in_is_store(in_is_store), .in_store_data(in_store_data), .in_dm_out(in_dm_out),
    .br_req(br_req), .br_we(br_we), .br_addr(br_addr), .br_wdata(br_wdata),
    .br_rdata(br_rdata), .br_ack(br_ack), .stall_req(stall_req), .bus_err(bus_err),
    .byp_reg_write(byp_reg_write), .byp_wd(byp_wd), .byp_rw(byp_rw),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_wd(wb_wd), .wb_rw(wb_rw)
`ifdef MEM_MISALIGN_CHK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(logic [31:0] addr, logic [31:0] data, logic [31:0] wdata,
                              bit st, bit m2r, bit regw, bit bt, bit hf, bit sg,
                              logic [4:0] rw, int ack_at, logic [31:0] exp_wd, bit exp_wrw);
    txn_t t;
    t.addr = addr; t.data = data; t.wdata = wdata;
    t.st = st; t.m2r = m2r; t.regw = regw; t.bt = bt; t.hf = hf; t.sg = sg;
    t.rw = rw; t.ack_at = ack_at; t.exp_wd = exp_wd; t.exp_wrw = exp_wrw;
    return t;
  endfunction

  function automatic bit is_periph(txn_t t);
    return (t.m2r || t.st) && (t.addr[15:0] >= 16'h3000);
  endfunction

  // Load extension expressed as lane extraction plus arithmetic sign fill.
  function automatic logic [31:0] ref_load(logic [31:0] raw, logic [31:0] a, bit bt, bit hf, bit sg);
    logic [31:0] v;
    if (bt) begin
      v = (raw >> (8 * a[1:0])) & 32'hFF;
      if (sg && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (hf) begin
      v = a[1] ? (raw >> 16) : (raw & 32'hFFFF);
      if (sg && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  task automatic apply(input txn_t t, input logic [31:0] dm);
    in_valid = 1'b1; in_ex_out = t.addr; in_rw = t.rw; in_reg_write = t.regw;
    in_mem_to_reg = t.m2r; in_is_byte = t.bt; in_is_half = t.hf; in_is_loads = t.sg;
    in_is_store = t.st; in_store_data = t.wdata; in_dm_out = dm;
  endtask

  task automatic chk_quiet(input string p);
    chk({p, "_br_req"}, 32'(br_req), 0);
    chk({p, "_br_we"}, 32'(br_we), 0);
    chk({p, "_br_addr"}, br_addr, 0);
    chk({p, "_br_wdata"}, br_wdata, 0);
    chk({p, "_stall_req"}, 32'(stall_req), 0);
    chk({p, "_bus_err"}, 32'(bus_err), 0);
    chk({p, "_wb_valid"}, 32'(wb_valid), 0);
    chk({p, "_wb_reg_write"}, 32'(wb_reg_write), 0);
    chk({p, "_wb_wd"}, wb_wd, 0);
    chk({p, "_wb_rw"}, 32'(wb_rw), 0);
  endtask

  // Starts at posedge+2; returns at posedge+2 after the edge that loads MEM/WB.
  task automatic run_txn(input string nm, input txn_t t);
    bit periph;
    int exp_req, exp_lat, n_req, n_stall, n_err, lat, wcnt;
    bit stable;
    periph  = is_periph(t);
    exp_req = periph ? ((t.ack_at == 0) ? TIMEOUT : t.ack_at) : 0;
    exp_lat = periph ? exp_req + 2 : 1;
    n_req = 0; n_stall = 0; n_err = 0; lat = 0; wcnt = 0; stable = 1'b1;
    apply(t, periph ? ~t.data : t.data);
    br_rdata = 32'hDEAD_0000;
    #1;
    chk({nm, "_byp_reg_write"}, 32'(byp_reg_write), 32'(t.regw));
    chk({nm, "_byp_wd"}, byp_wd, t.addr);
    chk({nm, "_byp_rw"}, 32'(byp_rw), 32'(t.rw));
    for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
      if (stall_req) n_stall++;
      if (bus_err) n_err++;
      if (br_req) begin
        n_req++;
        wcnt++;
        if (br_addr !== t.addr || br_we !== t.st || br_wdata !== t.wdata) stable = 1'b0;
        if (wcnt == t.ack_at) begin
          br_ack = 1'b1;
          br_rdata = t.data;
        end
      end
      @(posedge clk); #2;
      br_ack = 1'b0;
      br_rdata = 32'hDEAD_0000;
      if (wb_valid) lat = cyc;
      else #1;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_wb_wd"}, wb_wd, t.exp_wd);
    chk({nm, "_wb_reg_write"}, 32'(wb_reg_write), 32'(t.exp_wrw));
    chk({nm, "_wb_rw"}, 32'(wb_rw), 32'(t.rw));
    chk({nm, "_br_req_cycles"}, 32'(n_req), 32'(exp_req));
    chk({nm, "_stall_cycles"}, 32'(n_stall), periph ? 32'(exp_req + 1) : 0);
    chk({nm, "_bus_err_pulses"}, 32'(n_err), 32'(periph && t.ack_at == 0));
    chk({nm, "_br_stable"}, 32'(stable), 1);
    in_valid = 1'b0;
  endtask

  txn_t vec[15];

  initial begin
    vec[0]  = mk(32'h1003, 32'h80FF_FFFF, 0, 0,1,1, 1,0,1, 5'd1, 0, 32'hFFFF_FF80, 1);
    vec[1]  = mk(32'h1003, 32'h80FF_FFFF, 0, 0,1,1, 1,0,0, 5'd2, 0, 32'h0000_0080, 1);
    vec[2]  = mk(32'h1001, 32'h1234_5678, 0, 0,1,1, 1,0,1, 5'd3, 0, 32'h0000_0056, 1);
    vec[3]  = mk(32'h1002, 32'hABCD_1234, 0, 0,1,1, 0,1,1, 5'd4, 0, 32'hFFFF_ABCD, 1);
    vec[4]  = mk(32'h1000, 32'hABCD_8234, 0, 0,1,1, 0,1,0, 5'd5, 0, 32'h0000_8234, 1);
    vec[5]  = mk(32'h1000, 32'hABCD_8234, 0, 0,1,1, 0,1,1, 5'd6, 0, 32'hFFFF_8234, 1);
    vec[6]  = mk(32'h2FFC, 32'hDEAD_BEEF, 0, 0,1,1, 0,0,0, 5'd7, 0, 32'hDEAD_BEEF, 1);
    vec[7]  = mk(32'h0001_2FFC, 32'h1122_3344, 0, 0,1,1, 0,0,1, 5'd8, 0, 32'h1122_3344, 1);
    vec[8]  = mk(32'h7F00, 32'h0, 0, 0,0,1, 0,0,0, 5'd9, 0, 32'h0000_7F00, 1);
    vec[9]  = mk(32'h1000, 32'h0, 32'h99, 1,0,0, 0,0,0, 5'd0, 0, 32'h0000_1000, 0);
    vec[10] = mk(32'h7F10, 32'h1234_5678, 0, 0,1,1, 0,0,0, 5'd10, 3, 32'h1234_5678, 1);
    vec[11] = mk(32'h7F00, 32'h0, 32'hCAFE_F00D, 1,0,0, 0,0,0, 5'd0, 1, 32'h0000_7F00, 0);
    vec[12] = mk(32'h7F10, 32'h7777_7777, 0, 0,1,1, 0,0,0, 5'd11, 0, 32'h0, 1);
    vec[13] = mk(32'h3000, 32'h0000_00F0, 0, 0,1,1, 1,0,1, 5'd12, 2, 32'hFFFF_FFF0, 1);
    vec[14] = mk(32'h3002, 32'hBEEF_0000, 0, 0,1,1, 0,1,0, 5'd13, 1, 32'h0000_BEEF, 1);

    #3;
    chk_quiet("reset");
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;

    for (int i = 0; i < 15; i++) run_txn($sformatf("vec%0d", i), vec[i]);

    for (int i = 0; i < 60; i++) begin
      txn_t t;
      int op, sz;
      logic [31:0] raw;
      op = $urandom_range(0, 2);
      sz = $urandom_range(0, 2);
      t.addr = $urandom;
      t.addr[15:0] = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 'h2FFF))
                                                 : 16'($urandom_range('h3000, 'hFFFF));
      t.bt = (sz == 0); t.hf = (sz == 1); t.sg = 1'($urandom_range(0, 1));
      if (sz == 1) t.addr[0] = 1'b0;
      if (sz == 2) t.addr[1:0] = 2'b00;
      t.st = (op == 2); t.m2r = (op == 1); t.regw = (op != 2);
      t.rw = 5'($urandom); t.data = $urandom; t.wdata = $urandom;
      t.ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      raw = (is_periph(t) && t.ack_at == 0) ? 32'h0 : t.data;
      t.exp_wd = t.m2r ? ref_load(raw, t.addr, t.bt, t.hf, t.sg) : t.addr;
      t.exp_wrw = t.regw;
      run_txn($sformatf("rnd%0d", i), t);
    end

    // Flush and ack land together in WAIT cycle 2; the following ack must be ignored.
    apply(mk(32'h7F20, 0, 0, 0,1,1, 0,0,0, 5'd3, 0, 0, 0), 32'h0);
    br_rdata = 32'h5555_5555;
    @(posedge clk); #3;
    chk("flush_wait1_req", 32'(br_req), 1);
    @(posedge clk); #3;
    chk("flush_wait2_req", 32'(br_req), 1);
    flush = 1'b1; br_ack = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    apply(mk(32'h1000, 0, 0, 0,1,1, 0,0,0, 5'd4, 0, 0, 0), 32'h1111_1111);
    chk("flush_wb_valid", 32'(wb_valid), 0);
    chk("flush_wb_reg_write", 32'(wb_reg_write), 0);
    #1;
    chk("flush_br_req_drop", 32'(br_req), 0);
    chk("flush_stall_drop", 32'(stall_req), 0);
    @(posedge clk); #2;
    br_ack = 1'b0;
    chk("flush_next_wb_wd", wb_wd, 32'h1111_1111);
    chk("flush_next_wb_reg_write", 32'(wb_reg_write), 1);
    chk("flush_next_br_req", 32'(br_req), 0);
    chk("flush_next_bus_err", 32'(bus_err), 0);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of a bridge store.
    apply(mk(32'h7F40, 0, 32'h0BAD_F00D, 1,0,0, 0,0,0, 5'd0, 0, 0, 0), 32'h0);
    @(posedge clk); #3;
    chk("rstwait_br_req", 32'(br_req), 1);
    chk("rstwait_br_we", 32'(br_we), 1);
    rst = 1'b0;
    #1;
    chk_quiet("rstwait");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #2;
    chk("rstwait_after_br_req", 32'(br_req), 0);

`ifdef MEM_MISALIGN_CHK_EN
    apply(mk(32'h1001, 0, 0, 0,1,1, 0,1,1, 5'd6, 0, 0, 0), 32'h1234_5678);
    #1;
    chk("mis_half_stall", 32'(stall_req), 0);
    @(posedge clk); #2;
    chk("mis_half_pulse", 32'(misalign), 1);
    chk("mis_half_wb_reg_write", 32'(wb_reg_write), 0);
    chk("mis_half_wb_valid", 32'(wb_valid), 1);
    apply(mk(32'h7F02, 0, 0, 0,1,1, 0,0,0, 5'd7, 0, 0, 0), 32'h0);
    #1;
    chk("mis_word_stall", 32'(stall_req), 0);
    @(posedge clk); #2;
    chk("mis_word_pulse", 32'(misalign), 1);
    chk("mis_word_br_req", 32'(br_req), 0);
    chk("mis_word_wb_reg_write", 32'(wb_reg_write), 0);
    in_valid = 1'b0;
    @(posedge clk); #2;
    chk("mis_pulse_end", 32'(misalign), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised successor to the pipeline MEM stage.
- Selects load data from data memory (DM, result already in EX/MEM) or from the peripheral bridge.
- Bridge accesses (load and store) use a multi-cycle req/ack handshake with a stall request and a timeout.
- Performs byte/half load extension, drives the MEM bypass, and owns the MEM/WB register.

Parameters:
- RW_W, 5, destination register index width
- ADDR_CMP_W, 16, low address bits compared for DM/bridge decode
- DM_LIMIT, 'h3000, addresses with ex_out[ADDR_CMP_W-1:0] < DM_LIMIT hit DM; otherwise the bridge
- TIMEOUT, 15, max WAIT cycles before abort (>=1; counter width $clog2(TIMEOUT+1))

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  controller MEM flush
- in_valid  in  1  EX/MEM holds a real instruction
- in_ex_out  in  32  ALU result / address
- in_rw  in  RW_W  destination register
- in_reg_write, in_mem_to_reg, in_is_byte, in_is_half, in_is_loads, in_is_store  in  1 each  control
- in_store_data  in  32  store data
- in_dm_out  in  32  DM read word
- br_req  out  1  bridge request
- br_we  out  1  bridge write
- br_addr  out  32  bridge address
- br_wdata  out  32  bridge write data
- br_rdata  in  32  bridge read data
- br_ack  in  1  bridge completion
- stall_req  out  1  freeze IF..MEM
- bus_err  out  1  one-cycle timeout pulse
- byp_reg_write  out  1  MEM bypass (combinational)
- byp_wd  out  32  MEM bypass data
- byp_rw  out  RW_W  MEM bypass register
- wb_valid, wb_reg_write  out  1  MEM/WB register
- wb_wd  out  32  MEM/WB register
- wb_rw  out  RW_W  MEM/WB register

Behaviour:
- periph = in_valid & (in_mem_to_reg | in_is_store) & (in_ex_out[ADDR_CMP_W-1:0] >= DM_LIMIT).
- Bypass:
  - byp_reg_write = in_valid & in_reg_write.
  - byp_wd = in_ex_out; byp_rw = in_rw.
  - Load results are not forwarded; the stall detector handles them.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - periph & !flush -> WAIT. Latch br_addr = in_ex_out, br_we = in_is_store, br_wdata = in_store_data; clear the counter.
  - stall_req = periph (combinational), so the stall is visible in the same cycle.
- WAIT:
  - br_req = 1; stall_req = 1; counter increments each cycle.
  - br_ack -> DONE; capture br_rdata into rdata_q.
  - On counter == TIMEOUT-1 without ack -> DONE; rdata_q = 0; bus_err pulses for 1 cycle.
  - flush -> IDLE; br_req drops next cycle; a later br_ack is ignored.
  - Ack and flush in the same cycle: flush wins.
- DONE:
  - stall_req = 0; the MEM/WB register loads using rdata_q; next state IDLE unconditionally.
- br_req is registered: high exactly in WAIT cycles. Address, write enable and write data hold stable throughout WAIT.
- Raw load data = DONE ? rdata_q : in_dm_out.
- Load extension, selected by in_ex_out[1:0]:
  - Byte: lane [8k+7:8k], k = addr[1:0].
  - Half: [31:16] if addr[1], else [15:0].
  - Sign-extend when in_is_loads, else zero-extend.
- Write-back data: wd = in_mem_to_reg ? extended : in_ex_out.
- MEM/WB register, at each posedge:
  - If flush: wb_valid, wb_reg_write <= 0.
  - Else if stall_req: wb_valid, wb_reg_write <= 0 (bubble); wb_wd and wb_rw hold.
  - Else: load {in_valid, in_valid & in_reg_write, wd, in_rw}.
- Latency:
  - DM access: 1 cycle.
  - Bridge access with ack in WAIT cycle n (n >= 1): n+2 cycles from entering MEM to the WB register update.
- Reset (rst=0, async):
  - State IDLE; counter 0.
  - br_req, br_we, stall_req, bus_err = 0; br_addr, br_wdata, rdata_q = 0.
  - wb_valid, wb_reg_write, wb_wd, wb_rw = 0.
  - Reset mid-WAIT aborts the access immediately.
- Stores to DM are handled outside this block; here they only produce no register write.

Optional Feature:
- Macro MEM_MISALIGN_CHK_EN.
- When defined, a misaligned access (half with addr[0]=1, or word with addr[1:0]!=0, on a load or store) is handled as follows:
  - Adds output misalign (1-bit, registered, one-cycle pulse).
  - Suppresses the bridge access (periph forced 0).
  - Forces the WB register to wb_reg_write = 0.
- When not defined, the port is absent and addresses are used unmodified (low bits ignored for words).

Test Plan:
- Reset release, DM signed byte load, in_ex_out=0x0000_1003, dm_out=0x80FF_FFFF -> next cycle wb_wd=0xFFFF_FF80, wb_reg_write=1, stall_req never high.
- Bridge load at 0x7F10, ack in WAIT cycle 3 with rdata=0x1234_5678 -> br_req high 3 cycles, stall_req high 4 cycles, wb_wd=0x1234_5678 2 cycles after ack.
- Bridge store at 0x7F00, data 0xCAFE_F00D, ack in cycle 1 -> br_we=1, br_wdata stable, wb_reg_write=0.
- No ack, TIMEOUT=15 -> br_req high 15 cycles, bus_err one pulse, DONE with wb_wd=0 for a load.
- Flush in WAIT cycle 2, then ack next cycle -> FSM in IDLE, br_req=0, wb_valid=0, ack ignored.
- rst asserted mid-WAIT -> all outputs 0 immediately; with MEM_MISALIGN_CHK_EN, half load at 0x1001 -> misalign pulse, wb_reg_write=0.
